// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock LSB first, through a
// single full-subtractor slice with a registered borrow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic d_bit;
  logic bo_bit;

  // Full-subtractor slice on the operand LSBs and the stored borrow.
  assign d_bit  = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign bo_bit = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        acc_d  = {d_bit, acc_q[WIDTH-1:1]};
        br_d   = bo_bit;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          diff_d  = {d_bit, acc_q[WIDTH-1:1]};
          bout_d  = bo_bit;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  // start/done handshake: start is sampled only in IDLE; done pulses one cycle.
  assign busy      = (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed vector table, hand-written corner
// sequences and random operands at WIDTH = 8 and WIDTH = 13.
module tb_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        start8, start13;
  logic [7:0]  a8, b8;
  logic [12:0] a13, b13;
  logic        busy8, done8, bout8;
  logic        busy13, done13, bout13;
  logic [7:0]  diff8;
  logic [12:0] diff13;
  logic [1:0]  st8, st13;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;
  vec_t vt[8];

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .state_dbg(st8)
  );

  serial_subtractor #(.WIDTH(13)) u13 (
    .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13),
    .busy(busy13), .done(done13), .diff(diff13), .bout(bout13), .state_dbg(st13)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Driver + scoreboard: issues one operation and checks busy, latency and result.
  task automatic run_op(input bit wide, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ed, input logic eb, input string nm);
    int w;
    int lat;
    logic [32:0] e;
    w = wide ? 13 : 8;
    exp_q.push_back({eb, ed});
    @(negedge clk);
    if (wide) begin a13 = av[12:0]; b13 = bv[12:0]; start13 = 1'b1; end
    else      begin a8  = av[7:0];  b8  = bv[7:0];  start8  = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    start8  = 1'b0;
    start13 = 1'b0;
    lat = 1;
    while (!(wide ? done13 : done8) && lat < 40) begin
      chk({nm, " busy"}, 32'(wide ? busy13 : busy8), 32'd1);
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(w + 1));
    chk({nm, " busy_in_done"}, 32'(wide ? busy13 : busy8), 32'd0);
    e = exp_q.pop_front();
    chk({nm, " diff"}, wide ? 32'(diff13) : 32'(diff8), e[31:0]);
    chk({nm, " bout"}, 32'(wide ? bout13 : bout8), 32'(e[32]));
  endtask

  initial begin
    int ndone;
    logic [7:0]  ra8, rb8;
    logic [12:0] ra13, rb13;

    vt[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    vt[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vt[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vt[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vt[4] = '{8'h80, 8'h01, 8'h7F, 1'b0};
    vt[5] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vt[6] = '{8'h01, 8'h02, 8'hFF, 1'b1};
    vt[7] = '{8'hA5, 8'h5A, 8'h4B, 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; start13 = 1'b0;
    a8 = '0; b8 = '0; a13 = '0; b13 = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy8), 32'd0);
    chk("reset done", 32'(done8), 32'd0);
    chk("reset diff", 32'(diff8), 32'd0);
    chk("reset bout", 32'(bout8), 32'd0);
    chk("reset state", 32'(st8), 32'd0);
    chk("reset diff13", 32'(diff13), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op(1'b0, 32'(vt[i].a), 32'(vt[i].b), 32'(vt[i].d), vt[i].bo,
             $sformatf("vec%0d", i));

    // Ignored start: new requests in SHIFT (cycle 3) and DONE (cycle 9).
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 20; k++) begin
      if (done8) ndone++;
      if (k == 9) chk("ign done_at_9", 32'(done8), 32'd1);
      if (k == 3 || k == 9) begin
        a8 = 8'hAA; b8 = 8'h11; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    chk("ign done_count", 32'(ndone), 32'd1);
    chk("ign diff", 32'(diff8), 32'h02);
    chk("ign bout", 32'(bout8), 32'd0);
    chk("ign state", 32'(st8), 32'd0);
    chk("ign busy", 32'(busy8), 32'd0);

    // Reset in the middle of SHIFT aborts the operation.
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst pre busy", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst busy", 32'(busy8), 32'd0);
    chk("rst done", 32'(done8), 32'd0);
    chk("rst diff", 32'(diff8), 32'd0);
    chk("rst bout", 32'(bout8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("rst no_done", 32'(ndone), 32'd0);
    chk("rst diff_after", 32'(diff8), 32'd0);
    run_op(1'b0, 32'h10, 32'h01, 32'h0F, 1'b0, "post_rst");

    // Random operands against (a - b) mod 2^W and (a < b).
    for (int i = 0; i < 1000; i++) begin
      ra8 = 8'($urandom_range(0, 255));
      rb8 = 8'($urandom_range(0, 255));
      run_op(1'b0, 32'(ra8), 32'(rb8), 32'(8'(ra8 - rb8)), ra8 < rb8, "rnd8");
      ra13 = 13'($urandom_range(0, 8191));
      rb13 = 13'($urandom_range(0, 8191));
      run_op(1'b1, 32'(ra13), 32'(rb13), 32'(13'(ra13 - rb13)), ra13 < rb13, "rnd13");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
